preg_release_queue: RTL and testbench
=====================================

// Module: preg_release_queue
// PURPOSE
//   Commit-side producer for the freelist free ports (write0/write1).
//   Buffers old physical registers released by ROB commit and drains up to
//   2 per cycle into the freelist in commit order. Sits between ROB commit
//   and the freelist, and decouples commit bursts from freelist update timing.
// PARAMETERS
//   PREG_IDX_WIDTH  6  physical register index width
//   DEPTH           8  buffer entries (power of 2, >= 4)
//   LOG_DEPTH       3  log2(DEPTH)
// PORTS
//   clock             in   1    clock, all state on rising edge
//   reset_n           in   1    asynchronous active-low reset
//   commit0_valid     in   1    commit slot 0 retires this cycle
//   commit0_need_free in   1    slot 0 has a destination whose old preg is released
//   commit0_old_preg  in   PREG_IDX_WIDTH  old preg of slot 0
//   commit1_valid     in   1    commit slot 1 retires this cycle
//   commit1_need_free in   1    slot 1 has a destination whose old preg is released
//   commit1_old_preg  in   PREG_IDX_WIDTH  old preg of slot 1
//   commit_ready      out  1    buffer can take 2 entries this cycle
//   rob_state         in   2    ROB state (`ROB_STATE_IDLE/ROLLBACK/WALK)
//   write0_valid      out  1    free port 0 to freelist
//   write0_data       out  PREG_IDX_WIDTH  preg freed on port 0
//   write1_valid      out  1    free port 1 to freelist
//   write1_data       out  PREG_IDX_WIDTH  preg freed on port 1
//   occupancy         out  LOG_DEPTH+1     entries currently buffered
// BEHAVIOUR
//   - Reset (async, reset_n=0): head=tail=0, occupancy=0, write*_valid=0,
//     write*_data=0, commit_ready=1. Buffered frees are discarded; the
//     freelist resets together with this block.
//   - Push filter: a slot pushes iff valid && need_free && old_preg!=0.
//     Preg 0 is the permanent x0 mapping and is never freed.
//   - Push order: slot 0 before slot 1. If only slot 1 pushes, it is packed
//     into tail (no hole left in the buffer).
//   - commit_ready = (occupancy <= DEPTH-2), computed from registered state.
//     The ROB asserts commit*_valid only with commit_ready=1. Commits with
//     commit_ready=0 are ignored (bench assertion).
//   - hold = (rob_state == `ROB_STATE_ROLLBACK). During hold, no drain
//     occurs and pushes continue.
//   - Drain (combinational from registered state):
//     write0_valid = !hold && occupancy>=1; write0_data = buf[head]
//     write1_valid = !hold && occupancy>=2; write1_data = buf[head+1]
//     write1_valid is never 1 while write0_valid is 0.
//     Data outputs are 0 when their valid is 0.
//   - pop = write0_valid + write1_valid. The popped entries are consumed at
//     the clock edge. The freelist has no backpressure.
//   - Latency: a preg pushed at edge N appears on a write port in the cycle
//     after edge N at the earliest. There is no same-cycle bypass.
//   - Update each edge: occupancy <= occupancy + push - pop; tail += push;
//     head += pop. The pointers are LOG_DEPTH bits and wrap mod DEPTH.
//     Simultaneous push and pop is legal. Overflow is impossible because
//     commit_ready is based on occupancy before the pop.
//   - WALK and IDLE states both drain normally. A walk never cancels
//     committed frees.
//   - Output order is exactly commit order across wrap-around.
// TESTING
//   1. Assert reset mid-stream with occupancy 5 -> occupancy=0,
//      write*_valid=0, commit_ready=1 immediately (async).
//   2. Commit slot 0 only, preg 33 -> next cycle write0=1/33, write1=0;
//      the cycle after that, both valids are 0.
//   3. Commit both slots, pregs 40 and 41 -> next cycle write0=40,
//      write1=41, occupancy back to 0.
//   4. Commit slot 1 only, preg 45 -> write0=45 next cycle (packed),
//      write1=0.
//   5. Slot 0 with preg 0 and slot 1 with need_free=0 -> no push; write
//      ports stay idle and occupancy stays 0.
//   6. Hold rob_state=ROLLBACK for 4 cycles with 2 commits/cycle (50..57)
//      -> occupancy 2,4,6,8; commit_ready=0 at 8; on return to IDLE, 4
//      cycles of pairs (50,51)...(56,57); commit_ready=1 once occupancy<=6.
//   7. Stream 20 single frees 32..51 while draining, with random holds ->
//      freelist sees 32..51 in order; no loss or duplication across
//      pointer wrap.

Source files
------------

// File: rtl/preg_release_queue.sv
// Commit-side release buffer: collects old physical registers freed at ROB commit
// and drains up to two per cycle, in commit order, into the freelist free ports.

`ifndef ROB_STATE_IDLE
`define ROB_STATE_IDLE     2'd0
`endif
`ifndef ROB_STATE_ROLLBACK
`define ROB_STATE_ROLLBACK 2'd1
`endif
`ifndef ROB_STATE_WALK
`define ROB_STATE_WALK     2'd2
`endif

module preg_release_queue #(
    parameter int PREG_IDX_WIDTH = 6,
    parameter int DEPTH          = 8,
    parameter int LOG_DEPTH      = 3
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      commit0_valid,
    input  logic                      commit0_need_free,
    input  logic [PREG_IDX_WIDTH-1:0] commit0_old_preg,
    input  logic                      commit1_valid,
    input  logic                      commit1_need_free,
    input  logic [PREG_IDX_WIDTH-1:0] commit1_old_preg,
    output logic                      commit_ready,
    input  logic [1:0]                rob_state,
    output logic                      write0_valid,
    output logic [PREG_IDX_WIDTH-1:0] write0_data,
    output logic                      write1_valid,
    output logic [PREG_IDX_WIDTH-1:0] write1_data,
    output logic [LOG_DEPTH:0]        occupancy
);

    logic [PREG_IDX_WIDTH-1:0] r_buf [DEPTH];
    logic [LOG_DEPTH-1:0]      r_head;
    logic [LOG_DEPTH-1:0]      r_tail;
    logic [LOG_DEPTH:0]        r_occ;

    logic                      w_hold;
    logic                      w_ready;
    logic                      w_push0;
    logic                      w_push1;
    logic [1:0]                w_push_cnt;
    logic [1:0]                w_pop_cnt;
    logic [LOG_DEPTH-1:0]      w_head_p1;
    logic [LOG_DEPTH-1:0]      w_tail_p1;
    logic [LOG_DEPTH-1:0]      w_slot1_idx;
    logic                      w_wr0_valid;
    logic                      w_wr1_valid;

    assign w_hold  = (rob_state == `ROB_STATE_ROLLBACK);
    assign w_ready = (r_occ <= (LOG_DEPTH+1)'(DEPTH - 2));

    // x0 is permanently mapped to preg 0, so it is never handed back.
    // Pushes are gated by ready so a misbehaving ROB cannot overrun the buffer.
    assign w_push0 = w_ready && commit0_valid && commit0_need_free
                     && (commit0_old_preg != '0);
    assign w_push1 = w_ready && commit1_valid && commit1_need_free
                     && (commit1_old_preg != '0);

    assign w_push_cnt = {1'b0, w_push0} + {1'b0, w_push1};

    assign w_head_p1   = r_head + LOG_DEPTH'(1);
    assign w_tail_p1   = r_tail + LOG_DEPTH'(1);
    assign w_slot1_idx = w_push0 ? w_tail_p1 : r_tail;

    assign w_wr0_valid = !w_hold && (r_occ >= (LOG_DEPTH+1)'(1));
    assign w_wr1_valid = !w_hold && (r_occ >= (LOG_DEPTH+1)'(2));
    assign w_pop_cnt   = {1'b0, w_wr0_valid} + {1'b0, w_wr1_valid};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            if (w_push0) begin
                r_buf[r_tail] <= commit0_old_preg;
            end
            if (w_push1) begin
                r_buf[w_slot1_idx] <= commit1_old_preg;
            end
            r_tail <= r_tail + LOG_DEPTH'(w_push_cnt);
            r_head <= r_head + LOG_DEPTH'(w_pop_cnt);
            r_occ  <= r_occ + (LOG_DEPTH+1)'(w_push_cnt) - (LOG_DEPTH+1)'(w_pop_cnt);
        end
    end

    assign commit_ready = w_ready;
    assign occupancy    = r_occ;
    assign write0_valid = w_wr0_valid;
    assign write1_valid = w_wr1_valid;
    assign write0_data  = w_wr0_valid ? r_buf[r_head]    : '0;
    assign write1_data  = w_wr1_valid ? r_buf[w_head_p1] : '0;

endmodule

// File: tb/tb_preg_release_queue.sv
// Scoreboard bench for preg_release_queue: the driver queues expected frees in
// commit order, a negedge monitor checks every freelist write against the queue.

`ifndef ROB_STATE_IDLE
`define ROB_STATE_IDLE     2'd0
`endif
`ifndef ROB_STATE_ROLLBACK
`define ROB_STATE_ROLLBACK 2'd1
`endif
`ifndef ROB_STATE_WALK
`define ROB_STATE_WALK     2'd2
`endif

module tb_preg_release_queue;

    localparam int PW = 6;
    localparam int DEPTH = 8;
    localparam int LD = 3;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          commit0_valid, commit0_need_free;
    logic [PW-1:0] commit0_old_preg;
    logic          commit1_valid, commit1_need_free;
    logic [PW-1:0] commit1_old_preg;
    logic          commit_ready;
    logic [1:0]    rob_state;
    logic          write0_valid, write1_valid;
    logic [PW-1:0] write0_data, write1_data;
    logic [LD:0]   occupancy;

    int tests = 0;
    int fails = 0;
    logic [PW-1:0] exp_q [$];

    preg_release_queue #(.PREG_IDX_WIDTH(PW), .DEPTH(DEPTH), .LOG_DEPTH(LD)) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .commit0_valid     (commit0_valid),
        .commit0_need_free (commit0_need_free),
        .commit0_old_preg  (commit0_old_preg),
        .commit1_valid     (commit1_valid),
        .commit1_need_free (commit1_need_free),
        .commit1_old_preg  (commit1_old_preg),
        .commit_ready      (commit_ready),
        .rob_state         (rob_state),
        .write0_valid      (write0_valid),
        .write0_data       (write0_data),
        .write1_valid      (write1_valid),
        .write1_data       (write1_data),
        .occupancy         (occupancy)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every write port beat must match the next expected free.
    always @(negedge clock) begin
        if (reset_n) begin
            if (rob_state == `ROB_STATE_ROLLBACK) begin
                check("no_drain_in_hold", int'(write0_valid || write1_valid), 0);
            end
            if (write1_valid && !write0_valid) begin
                check("write1_without_write0", 1, 0);
            end
            if (!write0_valid) check("write0_data_idle", int'(write0_data), 0);
            if (!write1_valid) check("write1_data_idle", int'(write1_data), 0);
            if (write0_valid) begin
                if (exp_q.size() == 0) check("write0_unexpected", int'(write0_data), -1);
                else check("write0_order", int'(write0_data), int'(exp_q.pop_front()));
            end
            if (write1_valid) begin
                if (exp_q.size() == 0) check("write1_unexpected", int'(write1_data), -1);
                else check("write1_order", int'(write1_data), int'(exp_q.pop_front()));
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v0, input logic nf0, input logic [PW-1:0] p0,
                         input logic v1, input logic nf1, input logic [PW-1:0] p1);
        if (v0 || v1) check("commit_ready_at_commit", int'(commit_ready), 1);
        commit0_valid = v0; commit0_need_free = nf0; commit0_old_preg = p0;
        commit1_valid = v1; commit1_need_free = nf1; commit1_old_preg = p1;
        if (v0 && nf0 && p0 != 0) exp_q.push_back(p0);
        if (v1 && nf1 && p1 != 0) exp_q.push_back(p1);
        step();
        commit0_valid = 0; commit0_need_free = 0; commit0_old_preg = '0;
        commit1_valid = 0; commit1_need_free = 0; commit1_old_preg = '0;
    endtask

    initial begin
        int r;
        int bound;
        logic [PW-1:0] nxt;
        reset_n = 0;
        rob_state = `ROB_STATE_IDLE;
        commit0_valid = 0; commit0_need_free = 0; commit0_old_preg = '0;
        commit1_valid = 0; commit1_need_free = 0; commit1_old_preg = '0;
        #1;
        check("rst_occupancy", int'(occupancy), 0);
        check("rst_commit_ready", int'(commit_ready), 1);
        check("rst_write0_valid", int'(write0_valid), 0);
        step();
        reset_n = 1;
        step();

        // 1: build occupancy 5 under hold, then async reset mid-cycle
        rob_state = `ROB_STATE_ROLLBACK;
        drive(1, 1, 6'd10, 1, 1, 6'd11);
        drive(1, 1, 6'd12, 1, 1, 6'd13);
        drive(1, 1, 6'd14, 0, 0, 6'd0);
        check("t1_occ_before_reset", int'(occupancy), 5);
        #2;
        reset_n = 0;
        #1;
        check("t1_occ_after_reset", int'(occupancy), 0);
        check("t1_w0v_after_reset", int'(write0_valid), 0);
        check("t1_w1v_after_reset", int'(write1_valid), 0);
        check("t1_ready_after_reset", int'(commit_ready), 1);
        exp_q.delete();
        rob_state = `ROB_STATE_IDLE;
        step();
        reset_n = 1;
        step();

        // 2: single free on slot 0
        drive(1, 1, 6'd33, 0, 0, 6'd0);
        check("t2_w0v", int'(write0_valid), 1);
        check("t2_w0d", int'(write0_data), 33);
        check("t2_w1v", int'(write1_valid), 0);
        step();
        check("t2_w0v_after", int'(write0_valid), 0);
        check("t2_w1v_after", int'(write1_valid), 0);

        // 3: pair of frees
        drive(1, 1, 6'd40, 1, 1, 6'd41);
        check("t3_w0d", int'(write0_data), 40);
        check("t3_w1v", int'(write1_valid), 1);
        check("t3_w1d", int'(write1_data), 41);
        step();
        check("t3_occ", int'(occupancy), 0);

        // 4: slot 1 only is packed at the tail
        drive(0, 0, 6'd0, 1, 1, 6'd45);
        check("t4_w0v", int'(write0_valid), 1);
        check("t4_w0d", int'(write0_data), 45);
        check("t4_w1v", int'(write1_valid), 0);
        step();

        // 5: filtered commits push nothing
        drive(1, 1, 6'd0, 1, 0, 6'd9);
        check("t5_occ", int'(occupancy), 0);
        check("t5_w0v", int'(write0_valid), 0);
        step();
        check("t5_occ_after", int'(occupancy), 0);

        // 6: fill under rollback, then drain pairs
        rob_state = `ROB_STATE_ROLLBACK;
        for (int k = 0; k < 4; k++) begin
            drive(1, 1, 6'(50 + 2*k), 1, 1, 6'(51 + 2*k));
            check("t6_fill_occ", int'(occupancy), 2*(k+1));
        end
        check("t6_ready_full", int'(commit_ready), 0);
        rob_state = `ROB_STATE_IDLE;
        #1;
        for (int k = 0; k < 4; k++) begin
            check("t6_w0d", int'(write0_data), 50 + 2*k);
            check("t6_w1d", int'(write1_data), 51 + 2*k);
            step();
            check("t6_drain_occ", int'(occupancy), 6 - 2*k);
            check("t6_ready", int'(commit_ready), 1);
        end

        // 7: stream 32..51 with random hold/walk states
        nxt = 6'd32;
        bound = 0;
        while (nxt <= 6'd51 && bound < 400) begin
            r = $urandom_range(0, 3);
            rob_state = (r == 0) ? `ROB_STATE_ROLLBACK :
                        (r == 1) ? `ROB_STATE_WALK : `ROB_STATE_IDLE;
            #1;
            if (commit_ready) begin
                if (nxt[0]) drive(0, 0, 6'd0, 1, 1, nxt);
                else        drive(1, 1, nxt, 0, 0, 6'd0);
                nxt = nxt + 6'd1;
            end else begin
                step();
            end
            bound++;
        end
        check("t7_all_issued", int'(nxt), 52);
        rob_state = `ROB_STATE_IDLE;
        bound = 0;
        while ((occupancy != 0 || exp_q.size() != 0) && bound < 50) begin
            step();
            bound++;
        end
        check("t7_drain_timeout", int'(bound < 50), 1);
        check("t7_queue_empty", exp_q.size(), 0);
        check("t7_occ_final", int'(occupancy), 0);

        step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
